booth_controller: RTL and testbench
===================================

BOOTH_CONTROLLER -- requirements
Module: booth_controller

Interface
REQ-001 The block SHALL have no parameters; iteration count is fixed at 4 by the 2-bit datapath counter.
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; inA/inB are stable this cycle.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous cancel of the operation in flight.
REQ-006 The block SHALL have port cntOut, input, 2 bits: datapath iteration counter value.
REQ-007 The block SHALL have port outReady, input, 1 bit: consumer accepts outR.
REQ-008 The block SHALL have port outValid, output, 1 bit: outR holds a final product.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have ports loadA, loadB, loadR, clearA, clearB, clearR, shiftA, cntE, loadC and clearC, each an output of 1 bit, driving the same-named datapath inputs.

Function
REQ-011 The FSM SHALL have the states IDLE, LOAD, CALC and DONE.
REQ-012 All outputs SHALL be Moore decodes of the state register only; start, abort, outReady and cntOut SHALL affect only next-state logic.
REQ-013 IDLE outputs SHALL all be 0; IDLE SHALL go to LOAD when start=1 and abort=0, and stay in IDLE otherwise.
REQ-014 LOAD SHALL assert loadA, loadB, clearR and clearC (all others 0) for exactly one cycle, then go to CALC.
REQ-015 CALC SHALL assert loadR, shiftA and cntE every cycle (all others 0), so R accumulates the partial product weighted by the current cntOut and the counter then increments.
REQ-016 CALC SHALL go to DONE on the edge where the sampled cntOut equals 2'b11; CALC SHALL last exactly 4 cycles.
REQ-017 DONE SHALL assert outValid (all datapath controls 0), so outR is held stable.
REQ-018 DONE SHALL stay in DONE while outReady=0, with outValid held high and outR unchanged.
REQ-019 DONE with outReady=1 and start=0 SHALL go to IDLE.
REQ-020 DONE with outReady=1 and start=1 SHALL go directly to LOAD (back-to-back operation, no IDLE bubble).
REQ-021 start SHALL be ignored in LOAD and CALC, and in DONE while outReady=0; no request queuing.
REQ-022 Latency: start=1 sampled at edge k SHALL give LOAD during cycle k+1, CALC during cycles k+2..k+5, and outValid=1 from cycle k+6.
REQ-023 Throughput SHALL be one product per 6 cycles under a continuous start with outReady=1.
REQ-024 abort=1 in LOAD, CALC or DONE SHALL force the next state to IDLE; on that edge clearR, clearA, clearB and clearC SHALL be pulsed for one cycle via a 1-cycle ABORT sub-state of IDLE.
REQ-025 abort has priority over start and outReady; abort in IDLE SHALL be a no-op.
REQ-026 An abort in DONE SHALL drop outValid on the next cycle without a handshake completing.
REQ-027 At most one of loadR and clearR, and at most one of loadC and clearC, SHALL be high in any cycle.
REQ-028 Illegal state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-029 While rst=0, the state SHALL be IDLE immediately (asynchronously), independent of clk.
REQ-030 While rst=0, all outputs SHALL be 0, including outValid and busy.
REQ-031 Reset asserted mid-CALC or in DONE SHALL discard the operation; no outValid SHALL follow reset release.
REQ-032 The first start SHALL be accepted on the first rising edge after rst returns to 1.

Verification
REQ-033 Basic multiply: controller plus datapath, inA=8'd7, inB=-8'd3, one start pulse, outReady=1 -> outValid at start+6 cycles, outR=16'hFFEB, then IDLE.
REQ-034 Corner operands: inA=-8'd128, inB=-8'd128 -> outR=16'h4000; inA=8'd127, inB=-8'd128 -> outR=16'hC080; each with exactly 4 cntE/loadR cycles.
REQ-035 Backpressure: outReady=0 for 5 cycles in DONE -> outValid stays 1 and outR is stable; outReady=1 -> IDLE the next cycle.
REQ-036 Back-to-back: start and outReady held at 1 -> the LOAD pulse recurs every 6 cycles, busy stays 1, and each product is correct.
REQ-037 Abort: abort=1 on the 2nd CALC cycle -> one-cycle clear pulse, then IDLE; outR=0 and outValid never asserts; a following start gives a correct product.
REQ-038 Async reset: rst=0 mid-edge during CALC -> all outputs 0 before the next clk edge; no outValid after release; start ignored while in LOAD/CALC.

Source files
------------

// File: rtl/booth_controller.sv
// Control FSM for a radix-4 Booth multiplier datapath: sequences load, four
// accumulate/shift iterations and an output handshake, with abort and async reset.
module booth_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] cntOut,
    input  logic       outReady,
    output logic       outValid,
    output logic       busy,
    output logic       loadA,
    output logic       loadB,
    output logic       loadR,
    output logic       clearA,
    output logic       clearB,
    output logic       clearR,
    output logic       shiftA,
    output logic       cntE,
    output logic       loadC,
    output logic       clearC
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    typedef struct packed {
        logic out_valid;
        logic busy;
        logic load_a;
        logic load_b;
        logic load_r;
        logic clear_a;
        logic clear_b;
        logic clear_r;
        logic shift_a;
        logic cnt_e;
        logic load_c;
        logic clear_c;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    // ABORT is a one-cycle clearing flavour of IDLE, so it is not busy and
    // accepts a new start exactly like IDLE does.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            LOAD: begin
                c.busy    = 1'b1;
                c.load_a  = 1'b1;
                c.load_b  = 1'b1;
                c.clear_r = 1'b1;
                c.clear_c = 1'b1;
            end
            CALC: begin
                c.busy    = 1'b1;
                c.load_r  = 1'b1;
                c.shift_a = 1'b1;
                c.cnt_e   = 1'b1;
            end
            DONE: begin
                c.busy      = 1'b1;
                c.out_valid = 1'b1;
            end
            ABORT: begin
                c.clear_a = 1'b1;
                c.clear_b = 1'b1;
                c.clear_r = 1'b1;
                c.clear_c = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Abort outranks every other input; unknown encodings fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ABORT: begin
                if (start && !abort) state_d = LOAD;
                else                 state_d = IDLE;
            end
            LOAD: begin
                if (abort) state_d = ABORT;
                else       state_d = CALC;
            end
            CALC: begin
                if (abort)                 state_d = ABORT;
                else if (cntOut == 2'b11)  state_d = DONE;
                else                       state_d = CALC;
            end
            DONE: begin
                if (abort)          state_d = ABORT;
                else if (outReady)  state_d = start ? LOAD : IDLE;
                else                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctrl_d = decode(state_d);
    end

    // Outputs are registered alongside the state so they are glitch-free Moore decodes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign outValid = ctrl_q.out_valid;
    assign busy     = ctrl_q.busy;
    assign loadA    = ctrl_q.load_a;
    assign loadB    = ctrl_q.load_b;
    assign loadR    = ctrl_q.load_r;
    assign clearA   = ctrl_q.clear_a;
    assign clearB   = ctrl_q.clear_b;
    assign clearR   = ctrl_q.clear_r;
    assign shiftA   = ctrl_q.shift_a;
    assign cntE     = ctrl_q.cnt_e;
    assign loadC    = ctrl_q.load_c;
    assign clearC   = ctrl_q.clear_c;

    a_r_exclusive : assert property (@(posedge clk) disable iff (!rst) !(loadR && clearR));
    a_c_exclusive : assert property (@(posedge clk) disable iff (!rst) !(loadC && clearC));
    a_moore       : assert property (@(posedge clk) disable iff (!rst) ctrl_q == decode(state_q));

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench: booth_controller driving a small radix-4 Booth datapath model,
// with hand-computed control words and products.
module tb_booth_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       outReady;
    logic [1:0] cntOut;
    logic       outValid, busy, loadA, loadB, loadR, clearA, clearB, clearR;
    logic       shiftA, cntE, loadC, clearC;

    logic [7:0]  inA, inB;
    logic [15:0] regA, regR;
    logic [7:0]  regB;
    logic [1:0]  regC;
    logic [11:0] ctrl;

    int checks;
    int failures;

    // Expected control words {outValid,busy,loadA,loadB,loadR,clearA,clearB,clearR,shiftA,cntE,loadC,clearC}
    localparam logic [15:0] IDLE_W  = 16'h0000;
    localparam logic [15:0] LOAD_W  = 16'h0711;
    localparam logic [15:0] CALC_W  = 16'h048C;
    localparam logic [15:0] DONE_W  = 16'h0C00;
    localparam logic [15:0] ABORT_W = 16'h0071;
    localparam logic [11:0] NO_BUSY = 12'hBFF;

    booth_controller dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cntOut   (cntOut),
        .outReady (outReady),
        .outValid (outValid),
        .busy     (busy),
        .loadA    (loadA),
        .loadB    (loadB),
        .loadR    (loadR),
        .clearA   (clearA),
        .clearB   (clearB),
        .clearR   (clearR),
        .shiftA   (shiftA),
        .cntE     (cntE),
        .loadC    (loadC),
        .clearC   (clearC)
    );

    assign ctrl   = {outValid, busy, loadA, loadB, loadR, clearA, clearB, clearR,
                     shiftA, cntE, loadC, clearC};
    assign cntOut = regC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] boothTerm(input logic [15:0] a, input logic [7:0] b,
                                              input logic [1:0] c);
        logic [8:0] bx;
        logic [2:0] trip;
        bx   = {b, 1'b0};
        trip = bx[{c, 1'b0} +: 3];
        case (trip)
            3'b001, 3'b010: return a;
            3'b011:         return a << 1;
            3'b100:         return -(a << 1);
            3'b101, 3'b110: return -a;
            default:        return 16'h0000;
        endcase
    endfunction

    // Datapath model: R accumulates digit(cnt) * A, A pre-shifted by 2 per iteration.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            regA <= '0;
            regB <= '0;
            regR <= '0;
            regC <= '0;
        end else begin
            if (clearA)      regA <= '0;
            else if (loadA)  regA <= {{8{inA[7]}}, inA};
            else if (shiftA) regA <= regA << 2;
            if (clearB)      regB <= '0;
            else if (loadB)  regB <= inB;
            if (clearR)      regR <= '0;
            else if (loadR)  regR <= regR + boothTerm(regA, regB, regC);
            if (clearC || loadC) regC <= '0;
            else if (cntE)       regC <= regC + 2'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic r);
        start    = s;
        abort    = a;
        outReady = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // start stays high through LOAD/CALC and held DONE to show it is ignored there.
    task automatic runMultiply(input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expR, input int hold);
        inA = a;
        inB = b;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        checkOutput("load", {4'h0, ctrl}, LOAD_W);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("calc", {4'h0, ctrl}, CALC_W);
        end
        step();
        checkOutput("done", {4'h0, ctrl}, DONE_W);
        checkOutput("product", regR, expR);
        for (int i = 0; i < hold; i++) begin
            step();
            checkOutput("hold_valid", {4'h0, ctrl}, DONE_W);
            checkOutput("hold_product", regR, expR);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        checkOutput("release_idle", {4'h0, ctrl}, IDLE_W);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0]  b2bA [3];
    logic [7:0]  b2bB [3];
    logic [15:0] b2bR [3];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        inA      = '0;
        inB      = '0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        #3;
        checkOutput("reset_async", {4'h0, ctrl}, IDLE_W);
        step();
        step();
        checkOutput("reset_hold", {4'h0, ctrl}, IDLE_W);
        #2 rst = 1'b1;

        $display("[TB] basic multiply 7 * -3");
        runMultiply(8'h07, 8'hFD, 16'hFFEB, 0);

        $display("[TB] corner operands");
        runMultiply(8'h80, 8'h80, 16'h4000, 0);
        runMultiply(8'h7F, 8'h80, 16'hC080, 5);

        $display("[TB] back-to-back");
        b2bA[0] = 8'h0C; b2bB[0] = 8'h0A; b2bR[0] = 16'h0078;
        b2bA[1] = 8'hFB; b2bB[1] = 8'h09; b2bR[1] = 16'hFFD3;
        b2bA[2] = 8'h64; b2bB[2] = 8'h9C; b2bR[2] = 16'hD8F0;
        inA = b2bA[0];
        inB = b2bB[0];
        applyStimulus(1'b1, 1'b0, 1'b1);
        step();
        checkOutput("b2b_load", {4'h0, ctrl}, LOAD_W);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                checkOutput("b2b_calc", {4'h0, ctrl}, CALC_W);
            end
            step();
            checkOutput("b2b_done", {4'h0, ctrl}, DONE_W);
            checkOutput("b2b_product", regR, b2bR[p]);
            if (p < 2) begin
                inA = b2bA[p + 1];
                inB = b2bB[p + 1];
                step();
                checkOutput("b2b_reload", {4'h0, ctrl}, LOAD_W);
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b1);
                step();
                checkOutput("b2b_idle", {4'h0, ctrl}, IDLE_W);
            end
        end

        $display("[TB] abort in CALC");
        inA = 8'h05;
        inB = 8'h06;
        applyStimulus(1'b1, 1'b0, 1'b1);
        step();
        checkOutput("abort_load", {4'h0, ctrl}, LOAD_W);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        checkOutput("abort_calc1", {4'h0, ctrl}, CALC_W);
        step();
        checkOutput("abort_calc2", {4'h0, ctrl}, CALC_W);
        applyStimulus(1'b0, 1'b1, 1'b1);
        step();
        checkOutput("abort_clear", {4'h0, ctrl & NO_BUSY}, ABORT_W);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        checkOutput("abort_idle", {4'h0, ctrl}, IDLE_W);
        checkOutput("abort_r_zero", regR, 16'h0000);
        step();
        checkOutput("abort_no_valid", {4'h0, ctrl}, IDLE_W);
        runMultiply(8'h05, 8'h06, 16'h001E, 0);

        $display("[TB] abort in DONE");
        inA = 8'h03;
        inB = 8'h03;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        checkOutput("abortd_done", {4'h0, ctrl}, DONE_W);
        checkOutput("abortd_product", regR, 16'h0009);
        applyStimulus(1'b1, 1'b1, 1'b1);
        step();
        checkOutput("abortd_clear", {4'h0, ctrl & NO_BUSY}, ABORT_W);
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();
        checkOutput("abortd_idle", {4'h0, ctrl}, IDLE_W);

        $display("[TB] abort in IDLE");
        applyStimulus(1'b1, 1'b1, 1'b0);
        step();
        checkOutput("abort_idle_noop", {4'h0, ctrl}, IDLE_W);
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();

        $display("[TB] async reset during CALC");
        inA = 8'h07;
        inB = 8'hFD;
        applyStimulus(1'b1, 1'b0, 1'b1);
        step();
        checkOutput("rst_load", {4'h0, ctrl}, LOAD_W);
        step();
        step();
        checkOutput("rst_calc", {4'h0, ctrl}, CALC_W);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_mid_calc", {4'h0, ctrl}, IDLE_W);
        step();
        checkOutput("rst_held", {4'h0, ctrl}, IDLE_W);
        applyStimulus(1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        step();
        checkOutput("rst_release", {4'h0, ctrl}, IDLE_W);
        step();
        step();
        checkOutput("rst_no_valid", {4'h0, ctrl}, IDLE_W);
        runMultiply(8'h7F, 8'h80, 16'hC080, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
